grid_scanner: RTL and testbench

GRID_SCANNER -- requirements
Module: grid_scanner

---
 rtl/grid_scanner_if.sv | 13 +
 rtl/grid_scanner.sv | 165 ++++++++++++++++
 tb/tb_grid_scanner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/grid_scanner_if.sv
// grid_scanner_if -- grid handoff bundle between a producer and grid_scanner.
//   grid        64-bit generation; row r, column c is grid[8*r+c]
//   grid_valid  producer offers grid this cycle
//   grid_ready  scanner can accept grid this cycle
// A transfer happens on a cycle with grid_valid and grid_ready both high.
interface grid_scanner_if;
  logic [63:0] grid;
  logic        grid_valid;
  logic        grid_ready;

  modport master (output grid, output grid_valid, input  grid_ready);
  modport slave  (input  grid, input  grid_valid, output grid_ready);
endinterface

// File: rtl/grid_scanner.sv
// grid_scanner -- scans a 64-bit (8x8) grid onto a row-multiplexed display.
// Each row is driven for DWELL cycles and is then followed by GAP blank cycles.
// A new grid is either loaded straight into the displayed (shadow) register,
// or parked in a one-deep pending buffer until the frame boundary.
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus          grid_scanner_if.slave: grid / grid_valid / grid_ready
//   row_sel      one-hot row drive (registered); all zeros means blank
//   col_data     column data for the driven row (registered)
//   frame_done   one-cycle pulse on the last cycle of each frame (registered)
//   alive_count  registered popcount of the displayed grid
module grid_scanner #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  grid_scanner_if.slave        bus,
  output logic [7:0]           row_sel,
  output logic [7:0]           col_data,
  output logic                 frame_done,
  output logic [6:0]           alive_count
);

  localparam int unsigned MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    shadow_q, shadow_d;
  logic [63:0]    pend_q, pend_d;
  logic           full_q, full_d;
  logic [7:0]     row_sel_q, row_sel_d;
  logic [7:0]     col_q, col_d;
  logic           fd_q, fd_d;
  logic [6:0]     alive_q, pop;
  logic           xfer;
  logic           last_cycle;

  // Final cycle of row 7's slot: the last blank cycle, or the last driven
  // cycle when there are no blank cycles.
  function automatic logic is_last(input state_t st, input logic [2:0] row,
                                   input logic [CW-1:0] cnt);
    if (GAP > 0)
      return (st == ST_GAP) && (row == 3'd7) && (cnt == GAP_LAST);
    else
      return (st == ST_ROW) && (row == 3'd7) && (cnt == DWELL_LAST);
  endfunction

  assign bus.grid_ready = ~full_q & ~reset;
  assign xfer           = bus.grid_valid & bus.grid_ready;
  assign last_cycle     = is_last(state_q, row_q, cnt_q);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    full_d   = full_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shadow_d = bus.grid;
          state_d  = ST_ROW;
          row_d    = 3'd0;
          cnt_d    = '0;
        end
      end
      ST_ROW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (GAP > 0) state_d = ST_GAP;
          else         row_d   = row_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_ROW;
          row_d   = row_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // While scanning, a new grid is only promoted at the frame boundary; an
    // accepted grid on that exact cycle skips the buffer.
    if (state_q != ST_IDLE) begin
      if (last_cycle) begin
        if (full_q) begin
          shadow_d = pend_q;
          full_d   = 1'b0;
        end else if (xfer) begin
          shadow_d = bus.grid;
        end
      end else if (xfer) begin
        pend_d = bus.grid;
        full_d = 1'b1;
      end
    end

    // Outputs are derived from the next state so that the registered values
    // line up with the state they describe.
    row_sel_d = '0;
    col_d     = '0;
    if (state_d == ST_ROW) begin
      row_sel_d = 8'b1 << row_d;
      col_d     = shadow_d[{row_d, 3'b000} +: 8];
    end
    fd_d = is_last(state_d, row_d, cnt_d);
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 64; i++)
      pop = pop + {6'd0, shadow_q[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      pend_q    <= '0;
      full_q    <= 1'b0;
      row_sel_q <= '0;
      col_q     <= '0;
      fd_q      <= 1'b0;
      alive_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      full_q    <= full_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fd_q      <= fd_d;
      alive_q   <= pop;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_q;
  assign frame_done  = fd_q;
  assign alive_count = alive_q;

endmodule

// File: tb/tb_grid_scanner.sv
// tb_grid_scanner -- directed bench for grid_scanner at default timing
// (DWELL=4, GAP=1) and at the DWELL=1, GAP=0 corner.
module tb_grid_scanner;

  localparam logic [63:0] G  = 64'h0412_6424_0034_3C28;  // 17 bits set
  localparam logic [63:0] GB = 64'h8040_2010_0804_0201;  // 8 bits set
  localparam logic [63:0] GC = 64'hAAAA_AAAA_AAAA_AAAA;  // must never show
  localparam logic [63:0] GF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2;
  logic [7:0] row_sel, col_data, row_sel2, col_data2;
  logic       frame_done, frame_done2;
  logic [6:0] alive, alive2;

  int checks = 0;
  int errors = 0;

  grid_scanner_if bus  ();
  grid_scanner_if bus2 ();

  grid_scanner dut (
    .clk(clk), .reset(reset), .bus(bus),
    .row_sel(row_sel), .col_data(col_data),
    .frame_done(frame_done), .alive_count(alive)
  );

  grid_scanner #(.DWELL(1), .GAP(0)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2),
    .row_sel(row_sel2), .col_data(col_data2),
    .frame_done(frame_done2), .alive_count(alive2)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 40-cycle frame starting at the current (row 0, first) cycle.
  // g is the grid expected on screen, a its popcount. If b_at >= 0, grid b is
  // offered on frame cycle b_at; with c_on, GC is then offered every later cycle.
  task automatic frame(input logic [63:0] g, input logic [6:0] a, input int b_at,
                       input logic [63:0] b, input bit c_on);
    for (int idx = 0; idx < 40; idx++) begin
      int r, ph;
      logic [7:0] exp_rs, exp_col;
      logic exp_rdy;
      r  = idx / 5;
      ph = idx % 5;
      if (idx == b_at) begin
        bus.grid = b; bus.grid_valid = 1'b1;
      end else if (c_on && b_at >= 0 && idx > b_at) begin
        bus.grid = GC; bus.grid_valid = 1'b1;
      end else begin
        bus.grid_valid = 1'b0;
      end
      exp_rs  = (ph < 4) ? (8'b1 << r) : 8'h00;
      exp_col = (ph < 4) ? g[8*r +: 8] : 8'h00;
      exp_rdy = (b_at < 0 || idx <= b_at) ? 1'b1 : 1'b0;
      check($sformatf("ready i%0d", idx), 64'(bus.grid_ready), 64'(exp_rdy));
      check($sformatf("row_sel i%0d", idx), 64'(row_sel), 64'(exp_rs));
      check($sformatf("col_data i%0d", idx), 64'(col_data), 64'(exp_col));
      check($sformatf("frame_done i%0d", idx), 64'(frame_done), 64'(idx == 39));
      if (idx > 0) check($sformatf("alive i%0d", idx), 64'(alive), 64'(a));
      step();
    end
    bus.grid_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bus.grid = '0;  bus.grid_valid = 1'b0;
    bus2.grid = '0; bus2.grid_valid = 1'b0;
    repeat (3) step();

    check("rst row_sel", 64'(row_sel), 64'(0));
    check("rst col_data", 64'(col_data), 64'(0));
    check("rst frame_done", 64'(frame_done), 64'(0));
    check("rst alive", 64'(alive), 64'(0));
    check("rst ready", 64'(bus.grid_ready), 64'(0));

    reset = 1'b0;
    step();
    check("post-rst ready", 64'(bus.grid_ready), 64'(1));
    check("idle row_sel", 64'(row_sel), 64'(0));
    step();
    check("idle hold row_sel", 64'(row_sel), 64'(0));

    // Load from IDLE, then two undisturbed frames.
    bus.grid = G; bus.grid_valid = 1'b1;
    step();
    bus.grid_valid = 1'b0;
    frame(G, 7'd17, -1, '0, 1'b0);
    frame(G, 7'd17, -1, '0, 1'b0);

    // Back-pressure: B mid-frame, C offered while pending is full.
    frame(G, 7'd17, 17, GB, 1'b1);
    frame(GB, 7'd8, -1, '0, 1'b0);

    // Bypass on the frame_done cycle with pending empty.
    frame(GB, 7'd8, 39, GF, 1'b0);
    frame(GF, 7'd64, -1, '0, 1'b0);

    // Reset during row 3 (frame cycles 15..18).
    for (int idx = 0; idx < 16; idx++) begin
      logic [7:0] exp_rs;
      exp_rs = ((idx % 5) < 4) ? (8'b1 << (idx / 5)) : 8'h00;
      check($sformatf("pre-abort row_sel i%0d", idx), 64'(row_sel), 64'(exp_rs));
      if (idx == 15) reset = 1'b1;
      step();
    end
    check("abort row_sel", 64'(row_sel), 64'(0));
    check("abort col_data", 64'(col_data), 64'(0));
    check("abort frame_done", 64'(frame_done), 64'(0));
    check("abort alive", 64'(alive), 64'(0));
    check("abort ready", 64'(bus.grid_ready), 64'(0));
    reset = 1'b0;
    step();
    check("rel ready", 64'(bus.grid_ready), 64'(1));
    check("rel row_sel", 64'(row_sel), 64'(0));
    step();
    check("rel idle row_sel", 64'(row_sel), 64'(0));
    check("rel alive", 64'(alive), 64'(0));

    // DWELL=1, GAP=0 corner.
    reset2 = 1'b0;
    step();
    check("c ready", 64'(bus2.grid_ready), 64'(1));
    bus2.grid = G; bus2.grid_valid = 1'b1;
    step();
    bus2.grid_valid = 1'b0;
    for (int idx = 0; idx < 16; idx++) begin
      logic [7:0] exp_rs, exp_col;
      int r;
      r = idx % 8;
      exp_rs  = 8'b1 << r;
      exp_col = G[8*r +: 8];
      check($sformatf("c row_sel i%0d", idx), 64'(row_sel2), 64'(exp_rs));
      check($sformatf("c col_data i%0d", idx), 64'(col_data2), 64'(exp_col));
      check($sformatf("c frame_done i%0d", idx), 64'(frame_done2), 64'(r == 7));
      step();
    end
    check("c alive", 64'(alive2), 64'(17));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
